// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB bridge controller.
// Holds the FSM state enum, AHB response codes and default widths.
package apb_ctrl_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NUM_SLAVES = 3;
  localparam int DEF_MAX_WAIT   = 16;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/apb_bridge_ctrl_if.sv
// Bus bundle between the AHB slave interface, the controller and APB.
// master: controller view (AHB/APB inputs in, P*/H* outputs out).
interface apb_bridge_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 3
);
  logic                  valid;
  logic                  Hwritereg;
  logic [ADDR_W-1:0]     Haddr1;
  logic [DATA_W-1:0]     Hwdata;
  logic [NUM_SLAVES-1:0] tempselx;
  logic                  Pready;
  logic                  Pslverr;
  logic [DATA_W-1:0]     Prdata;
  logic                  Pwrite;
  logic                  Penable;
  logic [NUM_SLAVES-1:0] Pselx;
  logic [ADDR_W-1:0]     Paddr;
  logic [DATA_W-1:0]     Pwdata;
  logic                  Hreadyout;
  logic [DATA_W-1:0]     Hrdata;
  logic                  Hresp;

  modport master (
    input  valid, Hwritereg, Haddr1, Hwdata,
    input  tempselx, Pready, Pslverr, Prdata,
    output Pwrite, Penable, Pselx, Paddr,
    output Pwdata, Hreadyout, Hrdata, Hresp
  );

  modport slave (
    output valid, Hwritereg, Haddr1, Hwdata,
    output tempselx, Pready, Pslverr, Prdata,
    input  Pwrite, Penable, Pselx, Paddr,
    input  Pwdata, Hreadyout, Hrdata, Hresp
  );
endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter: clr/en/pready in, one-cycle timeout out.
// MAX_WAIT=0 disables the timeout; the counter then just saturates.
module apb_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic pready,
  output logic timeout
);
  localparam int CW =
    (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST =
    CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !pready && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (MAX_WAIT != 0) && en &&
                   !pready && (cnt == LAST);
endmodule

// File: rtl/apb_bridge_ctrl.sv
// APB master controller for the AHB-to-APB bridge (Hclk, Hresetn, bus).
// Define APB_CTRL_ERR_RESP_EN for the two-cycle AHB error response.
module apb_bridge_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
  input  logic             Hclk,
  input  logic             Hresetn,
  apb_bridge_ctrl_if.master bus
);
  state_e                state, nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [DATA_W-1:0]     wdata_q;

  logic              accept, hready, hresp;
  logic              penable, psel_en;
  logic [DATA_W-1:0] rdata;
  logic              mapped, rdy, err, tmo, done;

  // Unmapped selects complete at once as errors.
  assign mapped = |sel_q;
  assign rdy    = bus.Pready | ~mapped;
  assign err    = (rdy & (bus.Pslverr | ~mapped)) | tmo;
  assign done   = rdy | tmo;

  apb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_tmr (
    .clk     (Hclk),
    .rst_n   (Hresetn),
    .clr     (state == ST_SETUP),
    .en      (state == ST_ACCESS),
    .pready  (rdy),
    .timeout (tmo)
  );

  always_ff @(posedge Hclk) begin
    if (!Hresetn) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt     = state;
    hready  = 1'b1;
    hresp   = HRESP_OKAY;
    rdata   = '0;
    accept  = 1'b0;
    penable = 1'b0;
    psel_en = 1'b0;
    unique case (state)
      ST_IDLE: accept = 1'b1;
      ST_WWAIT: begin
        hready = 1'b0;
        nxt    = ST_SETUP;
      end
      ST_SETUP: begin
        hready  = 1'b0;
        psel_en = 1'b1;
        nxt     = ST_ACCESS;
      end
      ST_ACCESS: begin
        penable = 1'b1;
        psel_en = 1'b1;
`ifdef APB_CTRL_ERR_RESP_EN
        if (err) begin
          hready = 1'b0;
          nxt    = ST_ERR1;
        end else if (done) begin
          accept = 1'b1;
          if (!write_q) rdata = bus.Prdata;
        end else begin
          hready = 1'b0;
        end
`else
        if (done) begin
          accept = 1'b1;
          if (!write_q && mapped && !tmo)
            rdata = bus.Prdata;
        end else begin
          hready = 1'b0;
        end
`endif
      end
`ifdef APB_CTRL_ERR_RESP_EN
      ST_ERR1: begin
        hready = 1'b0;
        hresp  = HRESP_ERROR;
        nxt    = ST_ERR2;
      end
      ST_ERR2: begin
        hresp  = HRESP_ERROR;
        accept = 1'b1;
      end
`endif
      default: nxt = ST_IDLE;
    endcase
    if (accept) begin
      if (!bus.valid)        nxt = ST_IDLE;
      else if (bus.Hwritereg) nxt = ST_WWAIT;
      else                   nxt = ST_SETUP;
    end
  end

`ifndef APB_CTRL_ERR_RESP_EN
  logic unused_err;
  assign unused_err = err;
`endif

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (accept && bus.valid) begin
        addr_q  <= bus.Haddr1;
        write_q <= bus.Hwritereg;
        sel_q   <= bus.tempselx;
      end
      if (state == ST_WWAIT) wdata_q <= bus.Hwdata;
    end
  end

  assign bus.Pselx     = psel_en ? sel_q : '0;
  assign bus.Paddr     = addr_q;
  assign bus.Pwrite    = write_q;
  assign bus.Pwdata    = wdata_q;
  assign bus.Penable   = penable;
  assign bus.Hreadyout = hready;
  assign bus.Hresp     = hresp;
  assign bus.Hrdata    = rdata;
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed bench for apb_bridge_ctrl (MAX_WAIT=4).
// Follows APB_CTRL_ERR_RESP_EN for the error-path expectations.
module tb_apb_bridge_ctrl;
  logic Hclk = 1'b0;
  logic Hresetn;
  int total = 0;
  int bad = 0;

  apb_bridge_ctrl_if #(32, 32, 3) bus ();

  apb_bridge_ctrl #(
    .ADDR_W(32), .DATA_W(32),
    .NUM_SLAVES(3), .MAX_WAIT(4)
  ) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  always #5 Hclk = ~Hclk;

  task automatic step;
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle_in;
    bus.valid = 0; bus.Hwritereg = 0;
    bus.Haddr1 = '0; bus.Hwdata = '0;
    bus.tempselx = '0; bus.Pready = 1;
    bus.Pslverr = 0; bus.Prdata = '0;
  endtask

  task automatic test_reset;
    idle_in();
    Hresetn = 0;
    step(); step();
    total++; if (bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 || bus.Pwrite !== 1'b0) begin bad++; $display("FAIL rst_apb sel=%b en=%b wr=%b want 000/0/0", bus.Pselx, bus.Penable, bus.Pwrite); end
    total++; if (bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0) begin bad++; $display("FAIL rst_data addr=%h wdata=%h want 0/0", bus.Paddr, bus.Pwdata); end
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 1'b0 || bus.Hrdata !== 32'h0) begin bad++; $display("FAIL rst_ahb rdy=%b resp=%b rdata=%h want 1/0/0", bus.Hreadyout, bus.Hresp, bus.Hrdata); end
    Hresetn = 1;
    step();
  endtask

  task automatic test_read;
    bus.valid = 1; bus.Hwritereg = 0;
    bus.Haddr1 = 32'h8040_0000; bus.tempselx = 3'b010;
    bus.Pready = 1; bus.Prdata = 32'hDEAD_BEEF;
    step(); bus.valid = 0; #1;
    total++; if (bus.Pselx !== 3'b010 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b0) begin bad++; $display("FAIL rd_setup sel=%b en=%b rdy=%b want 010/0/0", bus.Pselx, bus.Penable, bus.Hreadyout); end
    total++; if (bus.Paddr !== 32'h8040_0000 || bus.Pwrite !== 1'b0) begin bad++; $display("FAIL rd_addr addr=%h wr=%b want 80400000/0", bus.Paddr, bus.Pwrite); end
    step();
    total++; if (bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1) begin bad++; $display("FAIL rd_access en=%b rdy=%b want 1/1", bus.Penable, bus.Hreadyout); end
    total++; if (bus.Hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h want deadbeef", bus.Hrdata); end
    step();
    total++; if (bus.Pselx !== 3'b000 || bus.Hrdata !== 32'h0) begin bad++; $display("FAIL rd_idle sel=%b rdata=%h want 000/0", bus.Pselx, bus.Hrdata); end
  endtask

  task automatic test_write;
    bus.valid = 1; bus.Hwritereg = 1;
    bus.Haddr1 = 32'h8c00_1234; bus.tempselx = 3'b001;
    step(); bus.valid = 0; bus.Hwdata = 32'h8500_0000; #1;
    total++; if (bus.Hreadyout !== 1'b0 || bus.Pselx !== 3'b000 || bus.Penable !== 1'b0) begin bad++; $display("FAIL wr_wwait rdy=%b sel=%b en=%b want 0/000/0", bus.Hreadyout, bus.Pselx, bus.Penable); end
    step(); bus.Hwdata = 32'h0;
    for (int c = 2; c <= 3; c++) begin
      #1;
      total++; if (bus.Paddr !== 32'h8c00_1234 || bus.Pwdata !== 32'h8500_0000 || bus.Pwrite !== 1'b1 || bus.Pselx !== 3'b001) begin bad++; $display("FAIL wr_apb c%0d addr=%h wdata=%h wr=%b sel=%b", c, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Pselx); end
      total++; if (bus.Hreadyout !== (c == 3) || bus.Penable !== (c == 3)) begin bad++; $display("FAIL wr_hs c%0d rdy=%b en=%b want %0d", c, bus.Hreadyout, bus.Penable, c == 3); end
      if (c == 2) step();
    end
    total++; if (bus.Hrdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h want 0", bus.Hrdata); end
    step();
  endtask

  task automatic test_wait;
    bus.valid = 1; bus.Hwritereg = 0;
    bus.Haddr1 = 32'h8000_0040; bus.tempselx = 3'b100;
    bus.Prdata = 32'h1234_5678;
    step(); bus.valid = 0; bus.Pready = 0;
    step();
    for (int c = 1; c <= 4; c++) begin
      bus.Pready = (c == 4); #1;
      total++; if (bus.Penable !== 1'b1 || bus.Pselx !== 3'b100 || bus.Paddr !== 32'h8000_0040 || bus.Pwrite !== 1'b0) begin bad++; $display("FAIL wt_hold c%0d en=%b sel=%b addr=%h wr=%b", c, bus.Penable, bus.Pselx, bus.Paddr, bus.Pwrite); end
      total++; if (bus.Hreadyout !== (c == 4)) begin bad++; $display("FAIL wt_rdy c%0d got=%b want %0d", c, bus.Hreadyout, c == 4); end
      step();
    end
    total++; if (bus.Penable !== 1'b0 || bus.Hresp !== 1'b0) begin bad++; $display("FAIL wt_end en=%b resp=%b want 0/0", bus.Penable, bus.Hresp); end
  endtask

  task automatic test_slverr;
    bus.valid = 1; bus.Hwritereg = 1;
    bus.Haddr1 = 32'h8000_0010; bus.tempselx = 3'b100;
    step(); bus.valid = 0; bus.Hwdata = 32'h0000_1234;
    step(); step();
    bus.Pready = 1; bus.Pslverr = 1; #1;
`ifdef APB_CTRL_ERR_RESP_EN
    total++; if (bus.Hreadyout !== 1'b0 || bus.Hresp !== 1'b0 || bus.Penable !== 1'b1) begin bad++; $display("FAIL se_access rdy=%b resp=%b en=%b want 0/0/1", bus.Hreadyout, bus.Hresp, bus.Penable); end
    step(); bus.Pslverr = 0; #1;
    total++; if (bus.Hreadyout !== 1'b0 || bus.Hresp !== 1'b1 || bus.Pselx !== 3'b000 || bus.Penable !== 1'b0) begin bad++; $display("FAIL se_err1 rdy=%b resp=%b sel=%b en=%b", bus.Hreadyout, bus.Hresp, bus.Pselx, bus.Penable); end
    step();
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 1'b1) begin bad++; $display("FAIL se_err2 rdy=%b resp=%b want 1/1", bus.Hreadyout, bus.Hresp); end
`else
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 1'b0 || bus.Penable !== 1'b1) begin bad++; $display("FAIL se_ok rdy=%b resp=%b en=%b want 1/0/1", bus.Hreadyout, bus.Hresp, bus.Penable); end
    bus.Pslverr = 0;
`endif
    step();
    total++; if (bus.Hresp !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.Penable !== 1'b0) begin bad++; $display("FAIL se_idle resp=%b rdy=%b en=%b want 0/1/0", bus.Hresp, bus.Hreadyout, bus.Penable); end
  endtask

  task automatic test_timeout;
    bus.valid = 1; bus.Hwritereg = 0;
    bus.Haddr1 = 32'h8000_0080; bus.tempselx = 3'b010;
    bus.Prdata = 32'hCAFE_F00D;
    step(); bus.valid = 0; bus.Pready = 0;
    step();
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (bus.Hreadyout !== 1'b0 || bus.Penable !== 1'b1) begin bad++; $display("FAIL to_wait c%0d rdy=%b en=%b want 0/1", c, bus.Hreadyout, bus.Penable); end
      step();
    end
`ifdef APB_CTRL_ERR_RESP_EN
    total++; if (bus.Hreadyout !== 1'b0 || bus.Penable !== 1'b1) begin bad++; $display("FAIL to_fire rdy=%b en=%b want 0/1", bus.Hreadyout, bus.Penable); end
    step();
    total++; if (bus.Hresp !== 1'b1 || bus.Hreadyout !== 1'b0) begin bad++; $display("FAIL to_err1 resp=%b rdy=%b want 1/0", bus.Hresp, bus.Hreadyout); end
    step();
`else
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'h0 || bus.Hresp !== 1'b0) begin bad++; $display("FAIL to_fire rdy=%b rdata=%h resp=%b want 1/0/0", bus.Hreadyout, bus.Hrdata, bus.Hresp); end
`endif
    bus.Pready = 1;
    step();
    total++; if (bus.Penable !== 1'b0 || bus.Hresp !== 1'b0) begin bad++; $display("FAIL to_idle en=%b resp=%b want 0/0", bus.Penable, bus.Hresp); end
  endtask

  task automatic test_unmapped;
    bus.valid = 1; bus.Hwritereg = 0;
    bus.Haddr1 = 32'h9000_0000; bus.tempselx = 3'b000;
    bus.Prdata = 32'h5555_AAAA;
    step(); bus.valid = 0; bus.Pready = 0; #1;
    total++; if (bus.Pselx !== 3'b000 || bus.Hreadyout !== 1'b0) begin bad++; $display("FAIL um_setup sel=%b rdy=%b want 000/0", bus.Pselx, bus.Hreadyout); end
    step();
`ifdef APB_CTRL_ERR_RESP_EN
    total++; if (bus.Pselx !== 3'b000 || bus.Hreadyout !== 1'b0 || bus.Hrdata !== 32'h0) begin bad++; $display("FAIL um_access sel=%b rdy=%b rdata=%h", bus.Pselx, bus.Hreadyout, bus.Hrdata); end
    step();
    total++; if (bus.Hresp !== 1'b1) begin bad++; $display("FAIL um_err1 resp=%b want 1", bus.Hresp); end
    step();
`else
    total++; if (bus.Pselx !== 3'b000 || bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'h0) begin bad++; $display("FAIL um_access sel=%b rdy=%b rdata=%h", bus.Pselx, bus.Hreadyout, bus.Hrdata); end
`endif
    bus.Pready = 1;
    step();
  endtask

  task automatic test_back_to_back;
    bus.valid = 1; bus.Hwritereg = 1;
    bus.Haddr1 = 32'h8000_0100; bus.tempselx = 3'b001;
    step(); bus.Hwdata = 32'h0BAD_F00D;
    bus.Haddr1 = 32'h8000_0200; bus.Hwritereg = 0;
    step();
    total++; if (bus.Paddr !== 32'h8000_0100 || bus.Pwrite !== 1'b1) begin bad++; $display("FAIL bb_hold addr=%h wr=%b want 80000100/1", bus.Paddr, bus.Pwrite); end
    bus.tempselx = 3'b010; bus.Prdata = 32'h7777_0001;
    step();
    total++; if (bus.Hreadyout !== 1'b1 || bus.Pwdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL bb_wdone rdy=%b wdata=%h", bus.Hreadyout, bus.Pwdata); end
    step(); bus.valid = 0; #1;
    total++; if (bus.Pselx !== 3'b010 || bus.Penable !== 1'b0 || bus.Paddr !== 32'h8000_0200 || bus.Pwrite !== 1'b0) begin bad++; $display("FAIL bb_setup sel=%b en=%b addr=%h wr=%b", bus.Pselx, bus.Penable, bus.Paddr, bus.Pwrite); end
    step();
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'h7777_0001) begin bad++; $display("FAIL bb_rdone rdy=%b rdata=%h", bus.Hreadyout, bus.Hrdata); end
    step();
  endtask

  task automatic test_reset_mid;
    bus.valid = 1; bus.Hwritereg = 0;
    bus.Haddr1 = 32'h8000_0300; bus.tempselx = 3'b100;
    step(); bus.valid = 0; bus.Pready = 0;
    step(); #1;
    total++; if (bus.Penable !== 1'b1) begin bad++; $display("FAIL rm_access en=%b want 1", bus.Penable); end
    Hresetn = 0;
    step();
    total++; if (bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 || bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0 || bus.Pwrite !== 1'b0) begin bad++; $display("FAIL rm_apb sel=%b en=%b addr=%h wdata=%h wr=%b", bus.Pselx, bus.Penable, bus.Paddr, bus.Pwdata, bus.Pwrite); end
    total++; if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 1'b0 || bus.Hrdata !== 32'h0) begin bad++; $display("FAIL rm_ahb rdy=%b resp=%b rdata=%h", bus.Hreadyout, bus.Hresp, bus.Hrdata); end
    Hresetn = 1; bus.Pready = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait();
    test_slverr();
    test_timeout();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
